// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
//
// Receive-side frame assembler that sits directly after the UART sampler.
// The sampler delivers one majority-voted bit per bit_valid strobe; this block
// finds the start bit, shifts the data bits in LSB-first, optionally checks a
// parity bit, checks the stop bit(s) and presents the finished byte to the
// consumer (receive FIFO / colour-command decoder) through a valid/ready
// holding register.
//
// Build option:
//   UART_PARITY_EN  when defined, a parity bit follows the data bits and is
//                   checked against PARITY_ODD. When undefined, frames carry no
//                   parity bit and parity_err is always 0.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   STOP_BITS   stop bits checked (1 or 2)
//   PARITY_ODD  parity sense with UART_PARITY_EN: 0 even, 1 odd
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   bit_in       in   sampled bit, qualified by bit_valid
//   bit_valid    in   one-cycle strobe: bit_in carries a new bit
//   data         out  received byte, stable while data_valid and not accepted
//   data_valid   out  a byte is held for the consumer
//   data_ready   in   consumer accepts when data_valid && data_ready
//   frame_err    out  one-cycle pulse: a stop bit was sampled 0
//   parity_err   out  one-cycle pulse: parity mismatch
//   overrun_err  out  one-cycle pulse: good frame lost, holding register full
//   busy         out  high whenever the FSM is not in IDLE
//   state_dbg_o  out  current FSM state encoding, for observation only
//
// Handshake: data_valid rises when a good frame is loaded and stays high, with
// data unchanged, until a cycle in which data_ready is also high. That cycle is
// the transfer; data_valid drops on the following cycle unless a new frame is
// loaded on the same edge, in which case it stays high with the new byte.
// -----------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy,
    output logic [1:0]           state_dbg_o
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t               state_q,       state_d;
    logic [CNT_W-1:0]     bit_cnt_q,     bit_cnt_d;
    logic                 stop_cnt_q,    stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q,       shift_d;
    logic                 par_bad_q,     par_bad_d;
    logic                 stop_bad_q,    stop_bad_d;
    logic [DATA_BITS-1:0] data_q,        data_d;
    logic                 data_valid_q,  data_valid_d;
    logic                 frame_err_q,   frame_err_d;
    logic                 parity_err_q,  parity_err_d;
    logic                 overrun_err_q, overrun_err_d;

    logic stop_bad_now;
    logic last_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            shift_q       <= '0;
            par_bad_q     <= 1'b0;
            stop_bad_q    <= 1'b0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            shift_q       <= shift_d;
            par_bad_q     <= par_bad_d;
            stop_bad_q    <= stop_bad_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        stop_cnt_d    = stop_cnt_q;
        shift_d       = shift_q;
        par_bad_d     = par_bad_q;
        stop_bad_d    = stop_bad_q;
        data_d        = data_q;
        // An accepted byte is released unless a completion below reloads it.
        data_valid_d  = data_valid_q && !data_ready;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;
        stop_bad_now  = stop_bad_q | ~bit_in;
        // With a single stop bit the counter is never consulted.
        last_stop     = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bit_valid && !bit_in) begin
                    state_d    = S_DATA;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end

            S_DATA: begin
                if (bit_valid) begin
                    shift_d   = {bit_in, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end

            // Only reachable when the parity build option is on.
            S_PARITY: begin
                if (bit_valid) begin
                    par_bad_d = (^{shift_q, bit_in}) ^ (PARITY_ODD != 0);
                    state_d   = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_valid) begin
                    stop_bad_d = stop_bad_now;
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    if (last_stop) begin
                        state_d = S_IDLE;
                        if (stop_bad_now) begin
                            frame_err_d = 1'b1;
                        end else if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else if (!data_valid_q || data_ready) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                        end else begin
                            overrun_err_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;

`ifdef UART_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       data_ready;
    logic       sel2;

    logic [7:0] data;
    logic       data_valid, frame_err, parity_err, overrun_err, busy;
    logic [1:0] state_dbg;
    logic [7:0] data2;
    logic       data_valid2, frame_err2, parity_err2, overrun_err2, busy2;
    logic [1:0] state_dbg2;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid && !sel2),
        .data(data), .data_valid(data_valid), .data_ready(data_ready && !sel2),
        .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err),
        .busy(busy), .state_dbg_o(state_dbg)
    );

    uart_rx_framer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid && sel2),
        .data(data2), .data_valid(data_valid2), .data_ready(data_ready && sel2),
        .frame_err(frame_err2), .parity_err(parity_err2), .overrun_err(overrun_err2),
        .busy(busy2), .state_dbg_o(state_dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One framed byte; stp[0] is the first stop bit. A parity bit is inserted
    // when the parity build is active (even parity, inverted when bad_par).
    // data_ready is raised together with the final bit when rdy_last is set.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int n_stop,
                              input logic [1:0] stp, input logic rdy_last, input int gap);
        logic b[16];
        int   n;
        b[0] = 1'b0;
        for (int k = 0; k < 8; k++) b[1+k] = d[k];
        n = 9;
        if (PAR_ON) begin
            b[n] = (^d) ^ bad_par;
            n = n + 1;
        end
        for (int s = 0; s < n_stop; s++) begin
            b[n] = stp[s];
            n = n + 1;
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = b[i];
            if (i == n - 1) data_ready = rdy_last;
        end
        @(negedge clk);
        bit_valid  = 1'b0;
        bit_in     = 1'b1;
        data_ready = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic accept_one();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; bit_in = 1'b1; bit_valid = 1'b0; data_ready = 1'b0; sel2 = 1'b0;
        @(negedge clk);
        check("rst_dv",    {15'd0, data_valid}, 16'd0);
        check("rst_data",  {8'd0, data}, 16'd0);
        check("rst_busy",  {15'd0, busy}, 16'd0);
        check("rst_errs",  {13'd0, frame_err, parity_err, overrun_err}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: 0xA5, bits back-to-back
        send_frame(8'hA5, 1'b0, 1, 2'b11, 1'b0, 0);
        check("t1_dv",   {15'd0, data_valid}, 16'd1);
        check("t1_data", {8'd0, data}, 16'h00A5);
        check("t1_busy", {15'd0, busy}, 16'd0);
        check("t1_perr", {15'd0, parity_err}, 16'd0);
        accept_one();
        check("t1_dv_clr", {15'd0, data_valid}, 16'd0);

        // 2: stop bit 0
        send_frame(8'h3C, 1'b0, 1, 2'b00, 1'b0, 1);
        check("t2_ferr", {15'd0, frame_err}, 16'd1);
        check("t2_dv",   {15'd0, data_valid}, 16'd0);
        check("t2_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        check("t2_ferr_pulse", {15'd0, frame_err}, 16'd0);

        // 3: overrun then replace-on-accept
        send_frame(8'h11, 1'b0, 1, 2'b11, 1'b0, 2);
        check("t3_data11", {8'd0, data}, 16'h0011);
        @(negedge clk);
        check("t3_hold", {8'd0, data}, 16'h0011);
        send_frame(8'h22, 1'b0, 1, 2'b11, 1'b0, 0);
        check("t3_ovr",      {15'd0, overrun_err}, 16'd1);
        check("t3_keep",     {8'd0, data}, 16'h0011);
        check("t3_keep_dv",  {15'd0, data_valid}, 16'd1);
        @(negedge clk);
        check("t3_ovr_pulse", {15'd0, overrun_err}, 16'd0);
        send_frame(8'h22, 1'b0, 1, 2'b11, 1'b1, 0);
        check("t3_repl",     {8'd0, data}, 16'h0022);
        check("t3_repl_dv",  {15'd0, data_valid}, 16'd1);
        check("t3_repl_ovr", {15'd0, overrun_err}, 16'd0);

`ifdef UART_PARITY_EN
        // 4: parity, held 0x22 accepted first
        accept_one();
        send_frame(8'h07, 1'b0, 1, 2'b11, 1'b0, 0);
        check("t4_ok_dv",   {15'd0, data_valid}, 16'd1);
        check("t4_ok_data", {8'd0, data}, 16'h0007);
        check("t4_ok_perr", {15'd0, parity_err}, 16'd0);
        accept_one();
        send_frame(8'h07, 1'b1, 1, 2'b11, 1'b0, 0);
        check("t4_perr",    {15'd0, parity_err}, 16'd1);
        check("t4_perr_dv", {15'd0, data_valid}, 16'd0);
        send_frame(8'h22, 1'b0, 1, 2'b11, 1'b0, 0);
`endif

        // 5: reset mid-frame with a byte still held
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(1'($urandom_range(0, 1)));
        check("t5_busy_mid", {15'd0, busy}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_busy", {15'd0, busy}, 16'd0);
        check("t5_dv",   {15'd0, data_valid}, 16'd0);
        check("t5_data", {8'd0, data}, 16'd0);
        check("t5_errs", {13'd0, frame_err, parity_err, overrun_err}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h5A, 1'b0, 1, 2'b11, 1'b0, 2);
        check("t5_data5a", {8'd0, data}, 16'h005A);
        check("t5_dv5a",   {15'd0, data_valid}, 16'd1);
        accept_one();
        check("t5_dv_clr", {15'd0, data_valid}, 16'd0);

        // 6: two stop bits on the second instance
        sel2 = 1'b1;
        send_frame(8'h80, 1'b0, 2, 2'b01, 1'b0, 0);
        check("t6_ferr", {15'd0, frame_err2}, 16'd1);
        check("t6_dv",   {15'd0, data_valid2}, 16'd0);
        check("t6_busy", {15'd0, busy2}, 16'd0);
        send_frame(8'h80, 1'b0, 2, 2'b11, 1'b0, 1);
        check("t6_good",    {8'd0, data2}, 16'h0080);
        check("t6_good_dv", {15'd0, data_valid2}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            drive_bit(1'b1);
            check("t6_idle", {15'd0, busy2}, 16'd0);
        end
        check("t6_idle_errs", {13'd0, frame_err2, parity_err2, overrun_err2}, 16'd0);
        check("t6_dut1_quiet", {14'd0, data_valid, busy}, 16'd0);
        sel2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
